// File: rtl/csr_pkg.sv
// Shared definitions for the CSR sparse encoder/decoder pair: FSM encoding,
// frame-size constants and the raster position helper.
package csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_FLUSH = 2'd2
    } csr_state_e;

    localparam int CSR_IMAGE_SIZE_DEF = 36;
    localparam int CSR_FRAME_PIX_DEF  = CSR_IMAGE_SIZE_DEF * CSR_IMAGE_SIZE_DEF;

    function automatic int frame_pixels(input int size);
        return size * size;
    endfunction

    // Raster position of a (row, col) entry; the encoder uses the same mapping.
    function automatic int csr_position(input int row, input int col, input int size);
        return row * size + col;
    endfunction

endpackage

// File: rtl/csr_decoder.sv
// Expands a raster-ordered stream of sparse (value, col, row) entries back into
// a dense image_size x image_size pixel stream, with zeros between entries.
module csr_decoder
    import csr_pkg::*;
#(
    parameter int col_length         = 8,
    parameter int word_length        = 8,
    parameter int double_word_length = 16,
    parameter int image_size         = CSR_IMAGE_SIZE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [word_length-1:0]        in_value,
    input  logic [col_length-1:0]         in_col,
    input  logic [col_length-1:0]         in_row,
    input  logic                          in_last,
    input  logic                          in_empty,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [word_length-1:0]        out_data,
    output logic                          out_last,
    output logic [double_word_length-1:0] nnz_count,
    output logic                          err
);

    localparam int FRAME = frame_pixels(image_size);
    localparam logic [double_word_length-1:0] LAST_POS = double_word_length'(FRAME - 1);
    localparam logic [double_word_length-1:0] ONE      = double_word_length'(1);

    csr_state_e                    r_state;
    csr_state_e                    w_state_nxt;

    logic                          r_pend_valid;
    logic [word_length-1:0]        r_pend_value;
    logic [double_word_length-1:0] r_pend_pos;
    logic                          r_pend_last;
    logic                          r_pend_empty;
    logic                          r_pend_bad;

    logic [double_word_length-1:0] r_pos;
    logic [double_word_length-1:0] r_nnz;
    logic                          r_out_valid;
    logic [word_length-1:0]        r_out_data;
    logic                          r_out_last;
    logic                          r_err;

    logic                          w_adv;
    logic                          w_accept;
    logic                          w_consume;
    logic                          w_set_err;
    logic                          w_final;
    logic                          w_in_bad;
    logic [double_word_length-1:0] w_in_pos;
    logic [double_word_length-1:0] w_pos_nxt;
    logic [double_word_length-1:0] w_nnz_cur;
    logic [double_word_length-1:0] w_nnz_nxt;
    logic                          w_ov_nxt;
    logic [word_length-1:0]        w_od_nxt;
    logic                          w_ol_nxt;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = !rst && (!r_pend_valid || w_consume);
    assign w_accept = in_valid && in_ready;
    assign w_final  = (r_pos == LAST_POS);
    assign w_in_pos = double_word_length'(csr_position(int'(in_row), int'(in_col), image_size));
    // An empty end-of-frame marker carries no coordinates, so it is never out of range.
    assign w_in_bad = !(in_last && in_empty) &&
                      ((int'(in_col) >= image_size) || (int'(in_row) >= image_size));

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign nnz_count = r_nnz;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IDLE with a pending entry behaves exactly like EMIT at pos 0, so the first
    // pixel of a frame costs no extra cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_nnz_cur   = (r_state == ST_IDLE && r_pend_valid) ? '0 : r_nnz;
        w_nnz_nxt   = w_nnz_cur;
        w_pos_nxt   = r_pos;
        w_consume   = 1'b0;
        w_set_err   = 1'b0;
        w_ov_nxt    = r_out_valid;
        w_od_nxt    = r_out_data;
        w_ol_nxt    = r_out_last;
        case (r_state)
            ST_IDLE, ST_EMIT: begin
                if (r_state == ST_IDLE && r_pend_valid) begin
                    w_state_nxt = ST_EMIT;
                end
                if (w_adv) begin
                    w_ov_nxt = 1'b0;
                    w_ol_nxt = 1'b0;
                    if (r_pend_valid) begin
                        if (r_pend_last && r_pend_empty) begin
                            w_consume   = 1'b1;
                            w_state_nxt = ST_FLUSH;
                        end else if (r_pend_bad || r_pend_pos < r_pos) begin
                            w_consume = 1'b1;
                            w_set_err = 1'b1;
                            if (r_pend_last) begin
                                w_state_nxt = ST_FLUSH;
                            end
                        end else begin
                            w_ov_nxt  = 1'b1;
                            w_ol_nxt  = w_final;
                            w_od_nxt  = '0;
                            w_pos_nxt = w_final ? '0 : r_pos + ONE;
                            if (r_pend_pos == r_pos) begin
                                w_od_nxt  = r_pend_value;
                                w_consume = 1'b1;
                                w_nnz_nxt = w_nnz_cur + ONE;
                            end
                            // Reaching the final pixel without the last entry ends the frame in error.
                            if (w_final) begin
                                w_state_nxt = ST_IDLE;
                                if (!(w_consume && r_pend_last)) begin
                                    w_set_err = 1'b1;
                                end
                            end else if (w_consume && r_pend_last) begin
                                w_state_nxt = ST_FLUSH;
                            end
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (w_adv) begin
                    w_ov_nxt  = 1'b1;
                    w_od_nxt  = '0;
                    w_ol_nxt  = w_final;
                    w_pos_nxt = w_final ? '0 : r_pos + ONE;
                    if (w_final) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pos        <= '0;
            r_nnz        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
            end else if (w_consume) begin
                r_pend_valid <= 1'b0;
            end
            r_pos       <= w_pos_nxt;
            r_nnz       <= w_nnz_nxt;
            r_out_valid <= w_ov_nxt;
            r_out_data  <= w_od_nxt;
            r_out_last  <= w_ol_nxt;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entry payload is qualified by r_pend_valid and needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_value <= in_value;
            r_pend_pos   <= w_in_pos;
            r_pend_last  <= in_last;
            r_pend_empty <= in_empty;
            r_pend_bad   <= w_in_bad;
        end
    end

endmodule
